// File: rtl/wb_init_pkg.sv
// Shared definitions for the Wishbone single-cycle initiator: FSM encoding and timer width.
package wb_init_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Wide enough for any practical TIMEOUT value; the timer loads TIMEOUT-1.
  localparam int TMR_W = 16;

endpackage

// File: rtl/wb_initiator_if.sv
// Command, response and Wishbone master signal bundle for wb_initiator.
interface wb_initiator_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_adr;
  logic [31:0]       cmd_dat;
  logic [3:0]        cmd_sel;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_dat;
  logic              rsp_err;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [31:0]       wbm_dat_o;
  logic [31:0]       wbm_dat_i;
  logic              wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_init_timer.sv
// Bus-wait timeout: down-counter loaded with TIMEOUT-1 while clear, expires at terminal count.
module wb_init_timer
  import wb_init_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LOAD = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-cycle initiator: command in, one bus cycle, response out.
// Optional bus timeout enabled by defining WB_INIT_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a command
// BUS     | cyc/stb asserted, waiting for ack (or timeout)
// RESP    | response held until rsp_ready
module wb_initiator
  import wb_init_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            wb_clk_i,
  input  logic            rst,
  wb_initiator_if.master  bus
);

  logic [1:0]        state;
  logic              cyc_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_dat_q;
  logic              timeout_hit;

`ifdef WB_INIT_TIMEOUT_EN
  logic rsp_err_q;

  wb_init_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (wb_clk_i),
    .rst     (rst),
    .clear   (state != ST_BUS),
    .enable  (state == ST_BUS),
    .expired (timeout_hit)
  );

  assign bus.rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_INIT_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            we_q  <= bus.cmd_we;
            sel_q <= bus.cmd_sel;
            adr_q <= bus.cmd_adr;
            dat_q <= bus.cmd_dat;
            cyc_q <= 1'b1;
            state <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack wins over a timeout on the same edge.
          if (bus.wbm_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= we_q ? 32'h0 : bus.wbm_dat_i;
            rsp_valid_q <= 1'b1;
`ifdef WB_INIT_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= ST_RESP;
          end else if (timeout_hit) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_valid_q <= 1'b1;
`ifdef WB_INIT_TIMEOUT_EN
            rsp_err_q   <= 1'b1;
`endif
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator; timeout scenario follows WB_INIT_TIMEOUT_EN.
module tb_wb_initiator;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_initiator_if #(.ADDR_W(ADDR_W)) bus ();

  wb_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (clk),
    .rst      (rst),
    .bus      (bus)
  );

  task automatic drive_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    bus.cmd_valid = 1'b1;
  endtask

  task automatic rsp_handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin
      $display("FAIL reset_cyc_stb: got %b/%b expected 0/0", bus.wbm_cyc_o, bus.wbm_stb_o); errors++; end
    checks++; if (bus.wbm_we_o !== 1'b0 || bus.wbm_sel_o !== 4'h0) begin
      $display("FAIL reset_we_sel: got %b/%h expected 0/0", bus.wbm_we_o, bus.wbm_sel_o); errors++; end
    checks++; if (bus.wbm_adr_o !== 32'h0 || bus.wbm_dat_o !== 32'h0) begin
      $display("FAIL reset_adr_dat: got %h/%h expected 0/0", bus.wbm_adr_o, bus.wbm_dat_o); errors++; end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_dat !== 32'h0 || bus.rsp_err !== 1'b0) begin
      $display("FAIL reset_rsp: got %b/%h/%b expected 0/0/0", bus.rsp_valid, bus.rsp_dat, bus.rsp_err); errors++; end
    checks++; if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); errors++; end
    rst = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clk);
    drive_cmd(1'b1, 32'h3000_0000, 32'h0000_1234, 4'h3);
    checks++; if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL wr_cmd_ready: got %b expected 1", bus.cmd_ready); errors++; end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_dat   = 32'hFFFF_FFFF;
    bus.cmd_adr   = 32'h0;
    checks++; if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== 1'b1) begin
      $display("FAIL wr_bus_ctrl: got cyc=%b stb=%b we=%b expected 1/1/1",
               bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o); errors++; end
    checks++; if (bus.wbm_adr_o !== 32'h3000_0000 || bus.wbm_dat_o !== 32'h0000_1234 || bus.wbm_sel_o !== 4'h3) begin
      $display("FAIL wr_bus_fields: got adr=%h dat=%h sel=%h expected 30000000/00001234/3",
               bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o); errors++; end
    checks++; if (bus.cmd_ready !== 1'b0) begin
      $display("FAIL wr_busy_cmd_ready: got %b expected 0", bus.cmd_ready); errors++; end
    @(negedge clk);
    checks++; if (bus.wbm_stb_o !== 1'b1 || bus.wbm_dat_o !== 32'h0000_1234 || bus.wbm_adr_o !== 32'h3000_0000) begin
      $display("FAIL wr_stable: got stb=%b dat=%h adr=%h expected 1/00001234/30000000",
               bus.wbm_stb_o, bus.wbm_dat_o, bus.wbm_adr_o); errors++; end
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin
      $display("FAIL wr_drop: got cyc=%b stb=%b expected 0/0", bus.wbm_cyc_o, bus.wbm_stb_o); errors++; end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'h0 || bus.rsp_err !== 1'b0) begin
      $display("FAIL wr_rsp: got v=%b dat=%h err=%b expected 1/00000000/0",
               bus.rsp_valid, bus.rsp_dat, bus.rsp_err); errors++; end
    rsp_handshake();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      $display("FAIL wr_done: got rsp_valid=%b cmd_ready=%b expected 0/1", bus.rsp_valid, bus.cmd_ready); errors++; end
  endtask

  task automatic test_read();
    drive_cmd(1'b0, 32'h3000_0000, 32'h5555_5555, 4'hF);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== 1'b0) begin
      $display("FAIL rd_bus: got stb=%b we=%b expected 1/0", bus.wbm_stb_o, bus.wbm_we_o); errors++; end
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h0000_001B;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    checks++; if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin
      $display("FAIL rd_drop: got cyc=%b stb=%b expected 0/0", bus.wbm_cyc_o, bus.wbm_stb_o); errors++; end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'h0000_001B || bus.rsp_err !== 1'b0) begin
      $display("FAIL rd_rsp: got v=%b dat=%h err=%b expected 1/0000001b/0",
               bus.rsp_valid, bus.rsp_dat, bus.rsp_err); errors++; end
    rsp_handshake();
  endtask

  task automatic test_back_to_back();
    drive_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'hA5A5_0001;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    drive_cmd(1'b1, 32'h3000_0008, 32'hCAFE_0001, 4'hF);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'hA5A5_0001) begin
        $display("FAIL bp_hold[%0d]: got v=%b dat=%h expected 1/a5a50001", i, bus.rsp_valid, bus.rsp_dat); errors++; end
      checks++; if (bus.cmd_ready !== 1'b0 || bus.wbm_cyc_o !== 1'b0) begin
        $display("FAIL bp_stall[%0d]: got cmd_ready=%b cyc=%b expected 0/0", i, bus.cmd_ready, bus.wbm_cyc_o); errors++; end
      @(negedge clk);
    end
    rsp_handshake();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wbm_cyc_o !== 1'b0) begin
      $display("FAIL bp_release: got v=%b cmd_ready=%b cyc=%b expected 0/1/0",
               bus.rsp_valid, bus.cmd_ready, bus.wbm_cyc_o); errors++; end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h3000_0008 || bus.wbm_dat_o !== 32'hCAFE_0001) begin
      $display("FAIL bp_second: got cyc=%b adr=%h dat=%h expected 1/30000008/cafe0001",
               bus.wbm_cyc_o, bus.wbm_adr_o, bus.wbm_dat_o); errors++; end
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'h0) begin
      $display("FAIL bp_second_rsp: got v=%b dat=%h expected 1/00000000", bus.rsp_valid, bus.rsp_dat); errors++; end
    rsp_handshake();
  endtask

  task automatic test_spurious_ack();
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h1111_2222;
    repeat (3) @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      $display("FAIL spurious_ack: got v=%b cyc=%b cmd_ready=%b expected 0/0/1",
               bus.rsp_valid, bus.wbm_cyc_o, bus.cmd_ready); errors++; end
  endtask

  task automatic test_timeout();
    int n;
    drive_cmd(1'b1, 32'h3000_0010, 32'h0000_00AA, 4'h1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
`ifdef WB_INIT_TIMEOUT_EN
    while (bus.wbm_cyc_o === 1'b1 && n < 120) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != TIMEOUT) begin
      $display("FAIL to_cycles: got %0d stb cycles expected %0d", n, TIMEOUT); errors++; end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_dat !== 32'h0) begin
      $display("FAIL to_rsp: got v=%b err=%b dat=%h expected 1/1/00000000",
               bus.rsp_valid, bus.rsp_err, bus.rsp_dat); errors++; end
    rsp_handshake();
    drive_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h0000_0077;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_dat !== 32'h0000_0077) begin
      $display("FAIL to_ack_tie: got v=%b err=%b dat=%h expected 1/0/00000077",
               bus.rsp_valid, bus.rsp_err, bus.rsp_dat); errors++; end
    rsp_handshake();
`else
    while (bus.wbm_cyc_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 100 || bus.wbm_stb_o !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      $display("FAIL no_to_wait: got %0d cycles stb=%b v=%b expected 100/1/0", n, bus.wbm_stb_o, bus.rsp_valid); errors++; end
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin
      $display("FAIL no_to_rsp: got v=%b err=%b expected 1/0", bus.rsp_valid, bus.rsp_err); errors++; end
    rsp_handshake();
`endif
  endtask

  task automatic test_reset_mid_bus();
    drive_cmd(1'b1, 32'h3000_0020, 32'h0000_0042, 4'hF);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      $display("FAIL rst_mid_bus: got cyc=%b stb=%b v=%b expected 0/0/0",
               bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid); errors++; end
    @(negedge clk);
    rst = 1'b0;
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      $display("FAIL rst_no_rsp: got v=%b cyc=%b cmd_ready=%b expected 0/0/1",
               bus.rsp_valid, bus.wbm_cyc_o, bus.cmd_ready); errors++; end
    rst = 1'b1;
    drive_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h3000_0024) begin
      $display("FAIL rst_first_accept: got cyc=%b adr=%h expected 1/30000024", bus.wbm_cyc_o, bus.wbm_adr_o); errors++; end
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h0000_0099;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'h0000_0099) begin
      $display("FAIL rst_first_rsp: got v=%b dat=%h expected 1/00000099", bus.rsp_valid, bus.rsp_dat); errors++; end
    rsp_handshake();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;
    bus.wbm_dat_i = '0;
    bus.wbm_ack_i = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_spurious_ack();
    test_timeout();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, Wishbone address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles waiting for ack (used only with WB_INIT_TIMEOUT_EN).
REQ-003 SHALL have ports: wb_clk_i  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_we in 1 (1=write); cmd_adr in ADDR_W; cmd_dat in 32 (write data); cmd_sel in 4 (byte enables).
REQ-005 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_dat out 32 (read data, 0 for writes); rsp_err out 1 (timeout).
REQ-006 SHALL have Wishbone master ports: wbm_cyc_o out 1; wbm_stb_o out 1; wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o out ADDR_W; wbm_dat_o out 32; wbm_dat_i in 32; wbm_ack_i in 1.

Function
REQ-007 SHALL implement FSM states IDLE, BUS, RESP; all outputs registered except cmd_ready.
REQ-008 cmd_ready SHALL equal (state==IDLE); command accepted on edge where cmd_valid && cmd_ready.
REQ-009 On accept SHALL latch cmd fields into wbm_adr_o/dat_o/sel_o/we_o, set wbm_cyc_o=wbm_stb_o=1, go BUS; bus outputs visible the cycle after accept.
REQ-010 In BUS, address/data/sel/we SHALL stay stable until ack sampled.
REQ-011 On edge where wbm_ack_i=1 in BUS: cyc/stb SHALL drop to 0, rsp_dat<=wbm_dat_i if read else 0, rsp_err<=0, rsp_valid<=1, go RESP.
REQ-012 wbm_ack_i SHALL be ignored outside BUS (no response, no state change).
REQ-013 In RESP, rsp_valid/rsp_dat/rsp_err SHALL hold until rsp_valid && rsp_ready; then rsp_valid<=0, go IDLE.
REQ-014 Minimum transaction: accept at edge N, stb high N..M, ack at M, rsp_valid from M; next cmd accepted no earlier than edge after rsp handshake.
REQ-015 Only one transaction SHALL be outstanding; cmd_valid while not IDLE SHALL be stalled, not dropped.
REQ-016 wbm_cyc_o and wbm_stb_o SHALL always be equal (classic single cycles, no bursts).

Reset
REQ-017 rst asserted SHALL asynchronously force IDLE, cyc/stb/we=0, sel=0, adr=0, dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, timeout counter=0.
REQ-018 Reset mid-BUS SHALL drop cyc/stb immediately; the aborted transaction produces no response.
REQ-019 After rst deasserts, first command accepted on the first subsequent edge with cmd_valid.

Configuration
REQ-020 Macro WB_INIT_TIMEOUT_EN defined: counter counts cycles in BUS; when it reaches TIMEOUT without ack, cyc/stb drop, rsp_err<=1, rsp_dat<=0, go RESP; ack and timeout on same edge SHALL count as ack.
REQ-021 Macro undefined: no counter, BUS waits indefinitely, rsp_err tied 0.

Structure
REQ-022 Package wb_init_pkg SHALL hold the state encoding (IDLE=0, BUS=1, RESP=2, 2 bits) and the timeout counter width constant.
REQ-023 Timeout counter SHALL be one sub-module wb_init_timer (clear, enable, expired), instantiated only under WB_INIT_TIMEOUT_EN.

Verification
REQ-024 Write adr=0x30000000 dat=0x00001234 sel=0x3, responder acks 1 cycle after stb -> wbm_we_o=1, dat_o=0x00001234 stable until ack, rsp_valid with rsp_dat=0, rsp_err=0.
REQ-025 Read adr=0x30000000, responder returns 0x0000001B with ack -> rsp_dat=0x0000001B, rsp_err=0, cyc/stb low the cycle after ack.
REQ-026 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_dat stable, cmd_ready=0, second cmd_valid stalled then accepted after handshake.
REQ-027 With WB_INIT_TIMEOUT_EN, TIMEOUT=16, no ack -> cyc/stb drop after 16 BUS cycles, rsp_err=1, rsp_dat=0; without macro, cyc/stb stay high for 100 cycles.
REQ-028 rst asserted 2 cycles into BUS -> cyc/stb/rsp_valid 0 immediately, no response after release; spurious ack in IDLE -> no rsp_valid.
